// File: rtl/dcache_pkg.sv
// Shared types, default geometry and address-field helpers for the L1 data cache.
package dcache_pkg;

    localparam int unsigned INDEX_W_DEF = 6;
    localparam int unsigned OFFS_W_DEF  = 2;
    localparam int unsigned TAG_W_DEF   = 32 - INDEX_W_DEF - OFFS_W_DEF - 2;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        REFILL
    } dc_state_e;

    typedef enum logic [1:0] {
        BM_IDLE,
        BM_REQ,
        BM_GAP
    } bm_state_e;

    function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                             input int unsigned iw,
                                             input int unsigned ow);
        return addr >> (iw + ow + 2);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                               input int unsigned iw,
                                               input int unsigned ow);
        return (addr >> (ow + 2)) & ((32'd1 << iw) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_word(input logic [31:0] addr,
                                              input int unsigned ow);
        return (addr >> 2) & ((32'd1 << ow) - 32'd1);
    endfunction

    function automatic logic [31:0] make_addr(input logic [31:0] tag,
                                              input logic [31:0] idx,
                                              input logic [31:0] word,
                                              input int unsigned iw,
                                              input int unsigned ow);
        return (tag << (iw + ow + 2)) | (idx << (ow + 2)) | (word << 2);
    endfunction

    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/l1_dcache_if.sv
// Memory-side single-beat bus of the data cache (cyc/stb/we/sel/ack).
interface l1_dcache_if;

    logic        mem_cyc_o;
    logic        mem_stb_o;
    logic        mem_we_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;

    modport master (
        output mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );

    modport slave (
        input  mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );

endinterface

// File: rtl/dcache_beat_master.sv
// One bus beat per start: strobe until the first ack, then wait out the slave's
// stale re-ack (ack sampled low) before reporting done.
module dcache_beat_master
    import dcache_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  addr,
    input  logic         we,
    input  logic [31:0]  wdata,
    output logic         done,
    output logic [31:0]  rdata,
    l1_dcache_if.master  bus
);

    bm_state_e   st_q, st_d;
    logic        accept;
    logic        stb_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) st_q <= BM_IDLE;
        else     st_q <= st_d;
    end

    // A new beat may start in the very cycle the previous one completes.
    always_comb begin
        st_d   = st_q;
        done   = 1'b0;
        accept = 1'b0;
        case (st_q)
            BM_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    st_d   = BM_REQ;
                end
            end
            BM_REQ: begin
                if (bus.mem_ack_i) st_d = BM_GAP;
            end
            BM_GAP: begin
                if (!bus.mem_ack_i) begin
                    done = 1'b1;
                    if (start) begin
                        accept = 1'b1;
                        st_d   = BM_REQ;
                    end else begin
                        st_d = BM_IDLE;
                    end
                end
            end
            default: st_d = BM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            stb_q   <= 1'b1;
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end else if (st_q == BM_REQ && bus.mem_ack_i) begin
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= bus.mem_data_i;
        end
    end

    assign rdata          = rdata_q;
    assign bus.mem_cyc_o  = stb_q;
    assign bus.mem_stb_o  = stb_q;
    assign bus.mem_we_o   = we_q;
    assign bus.mem_sel_o  = 4'hF;
    assign bus.mem_addr_o = addr_q;
    assign bus.mem_data_o = wdata_q;

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with flop arrays.
// Hits complete combinationally; misses evict a dirty victim then refill.
module l1_dcache
    import dcache_pkg::*;
#(
    parameter int unsigned INDEX_W = INDEX_W_DEF,
    parameter int unsigned OFFS_W  = OFFS_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [3:0]   cpu_sel_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_wdata_i,
    output logic [31:0]  cpu_rdata_o,
    output logic         cpu_stall_o,
    l1_dcache_if.master  mem
);

    localparam int unsigned LINES = 1 << INDEX_W;
    localparam int unsigned WORDS = 1 << OFFS_W;
    localparam int unsigned TAG_W = 32 - INDEX_W - OFFS_W - 2;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS];

    dc_state_e         state_q, state_d;
    logic [OFFS_W-1:0] cnt_q, cnt_d;
    logic [INDEX_W-1:0] idx_q;
    logic [TAG_W-1:0]  vtag_q;
    logic [TAG_W-1:0]  rtag_q;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [OFFS_W-1:0]  req_word;
    logic               hit;
    logic               store_hit;
    logic               load_hit;

    logic               latch_miss;
    logic               refill_wr;
    logic               fill_done;
    logic               bm_start;
    logic               bm_we;
    logic [TAG_W-1:0]   bm_tag;
    logic [INDEX_W-1:0] bm_idx;
    logic [OFFS_W-1:0]  bm_word;
    logic [31:0]        bm_addr;
    logic [31:0]        bm_wdata;
    logic               bm_done;
    logic [31:0]        bm_rdata;

    assign req_tag  = TAG_W'(addr_tag(cpu_addr_i, INDEX_W, OFFS_W));
    assign req_idx  = INDEX_W'(addr_index(cpu_addr_i, INDEX_W, OFFS_W));
    assign req_word = OFFS_W'(addr_word(cpu_addr_i, OFFS_W));

    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign store_hit = (state_q == IDLE) && cpu_req_i && cpu_we_i && hit;
    assign load_hit  = (state_q == IDLE) && cpu_req_i && !cpu_we_i && hit;

    assign cpu_stall_o = cpu_req_i && ((state_q != IDLE) || !hit);
    assign cpu_rdata_o = load_hit ? (data_q[req_idx][req_word] & sel_mask(cpu_sel_i)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The first beat is issued from the miss cycle itself, and each following
    // beat from the cycle the previous one completes, so no cycle is lost
    // between beats or across the WB-to-REFILL switch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch_miss = 1'b0;
        refill_wr  = 1'b0;
        fill_done  = 1'b0;
        bm_start   = 1'b0;
        bm_we      = 1'b0;
        bm_tag     = req_tag;
        bm_word    = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i && !hit) begin
                    latch_miss = 1'b1;
                    bm_start   = 1'b1;
                    if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d = WB;
                        bm_we   = 1'b1;
                        bm_tag  = tag_q[req_idx];
                    end else begin
                        state_d = REFILL;
                    end
                end
            end
            WB: begin
                bm_tag = vtag_q;
                if (bm_done) begin
                    cnt_d    = cnt_q + OFFS_W'(1);
                    bm_start = 1'b1;
                    bm_word  = cnt_q + OFFS_W'(1);
                    if (cnt_q == '1) begin
                        state_d = REFILL;
                        bm_tag  = rtag_q;
                    end else begin
                        bm_we = 1'b1;
                    end
                end
            end
            REFILL: begin
                bm_tag = rtag_q;
                if (bm_done) begin
                    refill_wr = 1'b1;
                    cnt_d     = cnt_q + OFFS_W'(1);
                    if (cnt_q == '1) begin
                        state_d   = IDLE;
                        fill_done = 1'b1;
                    end else begin
                        bm_start = 1'b1;
                        bm_word  = cnt_q + OFFS_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bm_idx   = (state_q == IDLE) ? req_idx : idx_q;
    assign bm_addr  = make_addr(32'(bm_tag), 32'(bm_idx), 32'(bm_word), INDEX_W, OFFS_W);
    assign bm_wdata = data_q[bm_idx][bm_word];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (store_hit) begin
            dirty_q[req_idx] <= 1'b1;
        end else if (fill_done) begin
            valid_q[idx_q] <= 1'b1;
            dirty_q[idx_q] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_miss) begin
            idx_q  <= req_idx;
            vtag_q <= tag_q[req_idx];
            rtag_q <= req_tag;
        end
        if (store_hit) begin
            data_q[req_idx][req_word] <= (data_q[req_idx][req_word] & ~sel_mask(cpu_sel_i))
                                       | (cpu_wdata_i & sel_mask(cpu_sel_i));
        end
        if (refill_wr) begin
            data_q[idx_q][cnt_q] <= bm_rdata;
        end
        if (fill_done) begin
            tag_q[idx_q] <= rtag_q;
        end
    end

    dcache_beat_master u_beat (
        .clk   (clk),
        .rst   (rst),
        .start (bm_start),
        .addr  (bm_addr),
        .we    (bm_we),
        .wdata (bm_wdata),
        .done  (bm_done),
        .rdata (bm_rdata),
        .bus   (mem)
    );

endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache against a registered-ack word RAM slave.
module tb_l1_dcache;
    import dcache_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        stall;

    l1_dcache_if bus ();

    l1_dcache #(.INDEX_W(6), .OFFS_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req_i   (req),
        .cpu_we_i    (we),
        .cpu_sel_i   (sel),
        .cpu_addr_i  (addr),
        .cpu_wdata_i (wdata),
        .cpu_rdata_o (rdata),
        .cpu_stall_o (stall),
        .mem         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic [31:0] ram [1024];
    beat_t       log_q [$];
    int unsigned stb_cyc = 0;
    logic        ack = 1'b0;
    logic [31:0] sdata = '0;

    assign bus.mem_ack_i  = ack;
    assign bus.mem_data_i = sdata;

    always @(posedge clk) begin
        if (bus.mem_stb_o && bus.mem_cyc_o && ack) begin
            log_q.push_back('{bus.mem_we_o, bus.mem_addr_o,
                              bus.mem_we_o ? bus.mem_data_o : sdata});
            if (bus.mem_we_o) ram[bus.mem_addr_o[11:2]] = bus.mem_data_o;
        end
        if (bus.mem_stb_o) stb_cyc++;
        ack   <= bus.mem_stb_o & bus.mem_cyc_o;
        sdata <= ram[bus.mem_addr_o[11:2]];
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] rdata;
        int unsigned stalls;
        int unsigned beats;
    } vec_t;

    task automatic run_vec(input vec_t v, input string name);
        int unsigned stalls;
        int unsigned b0;
        int unsigned s0;
        logic [31:0] rd;
        @(negedge clk);
        req   = 1'b1;
        we    = v.we;
        sel   = v.sel;
        addr  = v.addr;
        wdata = v.wdata;
        b0 = log_q.size();
        s0 = stb_cyc;
        stalls = 0;
        #1;
        while (stall !== 1'b0 && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        rd = rdata;
        if (v.chk_rd) check({name, " rdata"}, rd, v.rdata);
        check({name, " stall cycles"}, stalls, v.stalls);
        check({name, " bus beats"}, log_q.size() - b0, v.beats);
        check({name, " stb cycles"}, stb_cyc - s0, 2 * v.beats);
        @(negedge clk);
        req = 1'b0;
        we  = 1'b0;
    endtask

    vec_t tbl [16];

    initial begin
        int unsigned n0;
        int unsigned guard;
        logic [31:0] exp_wb [4];
        logic        idle_ok;

        for (int i = 0; i < 1024; i++) ram[i] = 32'h1000_0000 + 32'(i);
        ram[32'h40] = 32'd1;
        ram[32'h41] = 32'd2;
        ram[32'h42] = 32'd3;
        ram[32'h43] = 32'd4;

        //          we    sel    addr          wdata         chk   rdata         stl beats
        tbl[0]  = '{1'b0, 4'hF, 32'h0000_0100, 32'h0,        1'b1, 32'h0000_0001, 17, 4};
        tbl[1]  = '{1'b0, 4'hF, 32'h0000_0108, 32'h0,        1'b1, 32'h0000_0003, 0,  0};
        tbl[2]  = '{1'b1, 4'h2, 32'h0000_0104, 32'h0000_AB00, 1'b0, 32'h0,        0,  0};
        tbl[3]  = '{1'b0, 4'hF, 32'h0000_0104, 32'h0,        1'b1, 32'h0000_AB02, 0,  0};
        tbl[4]  = '{1'b0, 4'h2, 32'h0000_0104, 32'h0,        1'b1, 32'h0000_AB00, 0,  0};
        tbl[5]  = '{1'b0, 4'hF, 32'h0000_0500, 32'h0,        1'b1, 32'h1000_0140, 33, 8};
        tbl[6]  = '{1'b0, 4'hF, 32'h0000_0100, 32'h0,        1'b1, 32'h0000_0001, 17, 4};
        tbl[7]  = '{1'b1, 4'hF, 32'h0000_0508, 32'hDEAD_BEEF, 1'b0, 32'h0,        17, 4};
        tbl[8]  = '{1'b0, 4'hF, 32'h0000_0508, 32'h0,        1'b1, 32'hDEAD_BEEF, 0,  0};
        tbl[9]  = '{1'b0, 4'hF, 32'h0000_0104, 32'h0,        1'b1, 32'h0000_AB02, 33, 8};
        tbl[10] = '{1'b0, 4'hF, 32'h0000_0508, 32'h0,        1'b1, 32'hDEAD_BEEF, 17, 4};
        tbl[11] = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,        1'b1, 32'h1000_0000, 17, 4};
        tbl[12] = '{1'b0, 4'hF, 32'h0000_03FC, 32'h0,        1'b1, 32'h1000_00FF, 17, 4};
        tbl[13] = '{1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0,        1'b1, 32'h1000_03FF, 17, 4};
        tbl[14] = '{1'b0, 4'h8, 32'h0000_03FC, 32'h0,        1'b1, 32'h1000_0000, 17, 4};
        tbl[15] = '{1'b0, 4'hF, 32'h0000_03F0, 32'h0,        1'b1, 32'h1000_00FC, 0,  0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset cyc", {31'd0, bus.mem_cyc_o}, 32'd0);
        check("reset stb", {31'd0, bus.mem_stb_o}, 32'd0);
        check("reset we", {31'd0, bus.mem_we_o}, 32'd0);
        check("reset sel", {28'd0, bus.mem_sel_o}, 32'hF);
        check("reset addr", bus.mem_addr_o, 32'd0);
        check("reset wdata", bus.mem_data_o, 32'd0);

        idle_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (stall !== 1'b0 || bus.mem_cyc_o !== 1'b0 || bus.mem_stb_o !== 1'b0) idle_ok = 1'b0;
        end
        check("idle no request", {31'd0, idle_ok}, 32'd1);

        for (int i = 0; i < 16; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int k = 0; k < 4; k++) begin
            check($sformatf("cold read addr %0d", k), log_q[k].addr, 32'h100 + 32'(4 * k));
            check($sformatf("cold read data %0d", k), log_q[k].data, 32'(k + 1));
        end
        exp_wb[0] = 32'd1;
        exp_wb[1] = 32'h0000_AB02;
        exp_wb[2] = 32'd3;
        exp_wb[3] = 32'd4;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("evict we %0d", k), {31'd0, log_q[4 + k].we}, 32'd1);
            check($sformatf("evict addr %0d", k), log_q[4 + k].addr, 32'h100 + 32'(4 * k));
            check($sformatf("evict data %0d", k), log_q[4 + k].data, exp_wb[k]);
            check($sformatf("evict refill addr %0d", k), log_q[8 + k].addr, 32'h500 + 32'(4 * k));
            check($sformatf("evict refill we %0d", k), {31'd0, log_q[8 + k].we}, 32'd0);
        end

        // Reset while the second refill beat of a fresh line is on the bus.
        @(negedge clk);
        req  = 1'b1;
        we   = 1'b0;
        sel  = 4'hF;
        addr = 32'h0000_0200;
        n0 = log_q.size();
        guard = 0;
        while (log_q.size() == n0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("rst_mid first beat seen", log_q.size() - n0, 32'd1);
        guard = 0;
        #1;
        while (bus.mem_stb_o !== 1'b1 && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("rst_mid second beat strobing", {31'd0, bus.mem_stb_o}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid stb low", {31'd0, bus.mem_stb_o}, 32'd0);
        check("rst_mid cyc low", {31'd0, bus.mem_cyc_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mid idle stall", {31'd0, stall}, 32'd0);

        run_vec('{1'b0, 4'hF, 32'h0000_0200, 32'h0, 1'b1, 32'h1000_0080, 17, 4}, "after reset 0x200");
        run_vec('{1'b0, 4'hF, 32'h0000_0104, 32'h0, 1'b1, 32'h0000_AB02, 17, 4}, "after reset 0x104");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/l1_dcache.md
# l1_dcache

Direct-mapped, write-back, write-allocate L1 data cache between the MIPS32 core's MEM stage and the word-addressed data RAM. Hits on loads and stores complete in the cycle they are presented. Misses stall the pipeline while the block evicts the victim line if it is dirty, then refills the line. Both transfers use single-word bus beats on the cyc/stb/we/sel/ack bus, against a slave whose `ack` is registered one cycle after `stb`.

## Interface
- `INDEX_W`, default 6: line index width; 64 lines.
- `OFFS_W`, default 2: word-in-line width; 4 words (16 B) per line. Tag is `addr[31:INDEX_W+OFFS_W+2]`.
- `clk`  in  1  clock. Reset is `rst`, synchronous, active-high; clock is `clk`.
- `rst`  in  1  synchronous active-high reset.
- `cpu_req_i`  in  1  access request; held stable while `cpu_stall_o` is high.
- `cpu_we_i`  in  1  1 = store.
- `cpu_sel_i`  in  4  byte lanes.
- `cpu_addr_i`  in  32  byte address; bits [1:0] are ignored.
- `cpu_wdata_i`  in  32  store data.
- `cpu_rdata_o`  out  32  load data, combinational. Unselected lanes are 0.
- `cpu_stall_o`  out  1  combinational; high while `cpu_req_i` is high and the access cannot complete this cycle.
- `mem_cyc_o`, `mem_stb_o`  out  1  bus request, registered, always equal.
- `mem_we_o`  out  1  1 = write-back beat.
- `mem_sel_o`  out  4  always 4'hF.
- `mem_addr_o`  out  32  word-aligned beat address.
- `mem_data_o`  out  32  write-back data.
- `mem_data_i`  in  32  refill data.
- `mem_ack_i`  in  1  beat acknowledge.

## Operation
- **Arrays.** Arrays are flop-based: `valid[64]`, `dirty[64]`, `tag[64]`, `data[64][4]`.
- **Hit condition.** hit = `valid[idx]` and `tag[idx]` equals the address tag.
- **IDLE, load hit.** `cpu_rdata_o` = selected word masked by `cpu_sel_i`; stall = 0.
- **IDLE, store hit.** Write the selected bytes at the clock edge, set `dirty[idx]`, stall = 0.
- **IDLE, miss.** Stall = 1. Next state is WB if the victim is valid and dirty, otherwise REFILL. Latch the index, victim tag and request tag.
- **WB.** Four write beats for words 0..3 at address {victim tag, idx, word, 2'b00}. After the last beat completes, go to REFILL.
- **REFILL.** Four read beats for words 0..3 at address {req tag, idx, word, 2'b00}; each `mem_data_i` is captured on its ack. After the last beat completes: `tag` = req tag, `valid` = 1, `dirty` = 0, go to IDLE. The held request then hits, and a store sets dirty.
- **Beat rule.**
  - Raise `stb`/`cyc`.
  - On the first cycle `mem_ack_i` = 1, capture data and drop `stb`/`cyc` at that edge.
  - The slave re-acks once more because it sampled the stale `stb`. That ack is ignored.
  - The beat completes when `mem_ack_i` is sampled 0. Only then may the next beat start or the FSM leave WB/REFILL.
- **Beat counter.** A 2-bit counter; it wraps 3 to 0 at the WB-to-REFILL transition.
- **No request.** `cpu_req_i` = 0 in IDLE means no array update and stall = 0.

## Timing
- **Reset values.** All outputs are 0 except `mem_sel_o` = 4'hF. `cpu_rdata_o` is 0 with no hit. FSM = IDLE; `valid` and `dirty` are cleared.
- **Reset mid-transfer.** `stb`/`cyc` are low in the cycle after the reset edge. The partially refilled line stays invalid.
- **Beat length.** A beat takes exactly 4 cycles against a registered-ack slave: `stb` high for 2 cycles, then 2 cycles low.
- **Clean miss.** Stall is high for 17 cycles (miss cycle plus 16). The access completes in cycle 17.
- **Dirty miss.** Stall is high for 33 cycles.
- **Hit.** Stall = 0; zero added latency.
- **Back-to-back accesses.** A request that differs from the previous one is evaluated fresh in IDLE.
- **Same-index dirty-line churn.** Alternating tags on one index always write back before refilling.

## Structure
- **Package `dcache_pkg`.** Holds `INDEX_W`/`OFFS_W` defaults, derived `TAG_W`, the FSM state enum {IDLE, WB, REFILL}, and address-field extraction functions.
- **Sub-module `dcache_beat_master`.** Implements the single-beat bus handshake: start, addr, we, wdata in; done, rdata out. It owns the stale-ack gap rule. The top holds the arrays, hit logic and FSM.

## Test plan
- **Cold load miss.** Load from 0x100 after reset with RAM[0x40..0x43] = 1,2,3,4 → four read beats at 0x100/104/108/10C; stall for 17 cycles; `cpu_rdata_o` = 1; a following load from 0x108 hits with data 3 and stall = 0.
- **Byte store hit.** Store to 0x104 with sel = 4'b0010 and data 0x0000AB00 over word 2 → the next load returns 0x0000AB02; no bus activity.
- **Dirty eviction.** Dirty line at index 0x10, then a load from the same index with a different tag (0x500 vs 0x100) → 4 write beats to 0x100..0x10C carrying the modified words, then 4 reads from 0x500..0x50C; stall = 33 cycles.
- **Stale ack ignored.** Bench slave holds ack for 2 cycles → no extra beat and no double capture; refill data is correct.
- **Reset mid-operation.** Reset asserted during beat 2 of a refill → `stb` = 0 next cycle, FSM = IDLE; the next load of that address misses again.
- **Idle request.** `cpu_req_i` = 0 for 10 cycles → stall = 0, bus idle.
